// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes, ALUop encodings and FSM state type for alu_ctrl_pipe.
// The M-extension codes are only produced when ALUCTRL_RV32M_EN is defined.
package alu_ctrl_pkg;

    localparam logic [4:0] ALU_AND      = 5'b00000;
    localparam logic [4:0] ALU_OR       = 5'b00001;
    localparam logic [4:0] ALU_ADD      = 5'b00010;
    localparam logic [4:0] ALU_SLL      = 5'b00011;
    localparam logic [4:0] ALU_SLT      = 5'b00100;
    localparam logic [4:0] ALU_SLTU     = 5'b00101;
    localparam logic [4:0] ALU_SUB      = 5'b00110;
    localparam logic [4:0] ALU_XOR      = 5'b00111;
    localparam logic [4:0] ALU_SRL      = 5'b01000;
    localparam logic [4:0] ALU_SRA      = 5'b01010;
    localparam logic [4:0] ALU_MDU_BASE = 5'b10000;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MDU_WAIT = 1'b1
    } state_t;

    // Base operation selected by funct3 alone, before funct7 refinements.
    function automatic logic [4:0] funct3_code(input logic [2:0] f3);
        case (f3)
            3'b000:  funct3_code = ALU_ADD;
            3'b001:  funct3_code = ALU_SLL;
            3'b010:  funct3_code = ALU_SLT;
            3'b011:  funct3_code = ALU_SLTU;
            3'b100:  funct3_code = ALU_XOR;
            3'b101:  funct3_code = ALU_SRL;
            3'b110:  funct3_code = ALU_OR;
            default: funct3_code = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_ctrl_fifo.sv
// Small synchronous FIFO with extra-bit pointers; head data reads zero while empty.
module alu_ctrl_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    // Masking keeps never-written storage from leaking out after reset.
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/alu_ctrl_pipe.sv
// ALU control decoder feeding an output FIFO, with dispatch stalled during MDU ops.
// Optional macro ALUCTRL_RV32M_EN enables M-extension decode and the MDU_WAIT state.
module alu_ctrl_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W    = 5,
    parameter int DEPTH     = 2,
    parameter int TAG_W     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_aluop,
    input  logic [2:0]           in_funct3,
    input  logic                 in_funct7_5,
    input  logic                 in_funct7_0,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic                 out_illegal,
    output logic                 out_mdu,
    output logic [TAG_W-1:0]     out_tag,
    input  logic                 mdu_done,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_cnt
);
`ifdef ALUCTRL_RV32M_EN
    localparam logic MDU_EN = 1'b1;
`else
    localparam logic MDU_EN = 1'b0;
`endif
    localparam int ENT_W = CTRL_W + 2 + TAG_W;

    state_t               r_state;
    state_t               w_state_next;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [4:0]           w_dec_code;
    logic                 w_dec_ill;
    logic                 w_dec_mdu;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [ENT_W-1:0]     w_wdata;
    logic [ENT_W-1:0]     w_head;
    logic                 w_head_mdu;

    always_comb begin
        w_dec_code = ALU_AND;
        w_dec_ill  = 1'b0;
        w_dec_mdu  = 1'b0;
        case (in_aluop)
            ALUOP_MEM: w_dec_code = ALU_ADD;
            ALUOP_BR:  w_dec_code = ALU_SUB;
            ALUOP_R: begin
                if (in_funct7_0) begin
                    if (MDU_EN) begin
                        w_dec_code = ALU_MDU_BASE | {2'b00, in_funct3};
                        w_dec_mdu  = 1'b1;
                    end else begin
                        w_dec_ill = 1'b1;
                    end
                end else if (in_funct7_5) begin
                    if (in_funct3 == 3'b000)      w_dec_code = ALU_SUB;
                    else if (in_funct3 == 3'b101) w_dec_code = ALU_SRA;
                    else                          w_dec_ill  = 1'b1;
                end else begin
                    w_dec_code = funct3_code(in_funct3);
                end
            end
            default: begin
                if (in_funct3 == 3'b001 && (in_funct7_5 || in_funct7_0)) begin
                    w_dec_ill = 1'b1;
                end else if (in_funct3 == 3'b101) begin
                    if (in_funct7_0) w_dec_ill  = 1'b1;
                    else             w_dec_code = in_funct7_5 ? ALU_SRA : ALU_SRL;
                end else begin
                    w_dec_code = funct3_code(in_funct3);
                end
            end
        endcase
    end

    // in_ready ignores out_ready so a full FIFO refuses pushes even on a pop cycle.
    assign in_ready  = !w_full;
    assign w_push    = in_valid && in_ready;
    assign out_valid = (r_state == ST_RUN) && !w_empty;
    assign w_pop     = out_valid && out_ready;
    assign w_wdata   = {CTRL_W'(w_dec_code), w_dec_ill, w_dec_mdu, in_tag};

    alu_ctrl_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_ctrl    = w_head[ENT_W-1 -: CTRL_W];
    assign out_illegal = w_head[TAG_W+1];
    assign w_head_mdu  = w_head[TAG_W];
    assign out_tag     = w_head[TAG_W-1:0];
    assign out_mdu     = MDU_EN && w_head_mdu;
    assign busy        = MDU_EN && (r_state == ST_MDU_WAIT);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:      if (MDU_EN && w_pop && w_head_mdu) w_state_next = ST_MDU_WAIT;
            ST_MDU_WAIT: if (mdu_done) w_state_next = ST_RUN;
            default:     w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_err_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_push && w_dec_ill && !(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Self-checking bench for alu_ctrl_pipe: directed scenarios plus randomized traffic
// checked against a queue-based reference model. Honors ALUCTRL_RV32M_EN.
module tb_alu_ctrl_pipe;
    localparam int CTRL_W    = 5;
    localparam int DEPTH     = 2;
    localparam int TAG_W     = 4;
    localparam int ERR_CNT_W = 8;
    localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;
`ifdef ALUCTRL_RV32M_EN
    localparam bit MEN = 1'b1;
`else
    localparam bit MEN = 1'b0;
`endif

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_aluop;
    logic [2:0]           in_funct3;
    logic                 in_funct7_5;
    logic                 in_funct7_0;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [CTRL_W-1:0]    out_ctrl;
    logic                 out_illegal;
    logic                 out_mdu;
    logic [TAG_W-1:0]     out_tag;
    logic                 mdu_done;
    logic                 busy;
    logic [ERR_CNT_W-1:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_err  = 0;

    typedef struct {
        logic [4:0] ctrl;
        logic       ill;
        logic       mdu;
        logic [3:0] tag;
    } ent_t;

    ent_t q[$];
    bit   m_wait;

    alu_ctrl_pipe #(
        .CTRL_W    (CTRL_W),
        .DEPTH     (DEPTH),
        .TAG_W     (TAG_W),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_aluop    (in_aluop),
        .in_funct3   (in_funct3),
        .in_funct7_5 (in_funct7_5),
        .in_funct7_0 (in_funct7_0),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_illegal (out_illegal),
        .out_mdu     (out_mdu),
        .out_tag     (out_tag),
        .mdu_done    (mdu_done),
        .busy        (busy),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode from the opcode tables: funct3 names a base op, funct7 refines it.
    function automatic ent_t ref_decode(input logic [1:0] op, input logic [2:0] f3,
                                        input logic f75, input logic f70, input logic [3:0] tag);
        int   base [8];
        int   code;
        bit   ill;
        bit   mdu;
        ent_t e;
        base = '{2, 3, 4, 5, 7, 8, 1, 0};
        code = 0;
        ill  = 0;
        mdu  = 0;
        if (op == 2'd0) code = 2;
        else if (op == 2'd1) code = 6;
        else if (op == 2'd2) begin
            if (f70) begin
                if (MEN) begin code = 16 + int'(f3); mdu = 1; end
                else ill = 1;
            end else if (f75) begin
                if (f3 == 3'd0) code = 6;
                else if (f3 == 3'd5) code = 10;
                else ill = 1;
            end else code = base[f3];
        end else begin
            if (f3 == 3'd1 && (f75 || f70)) ill = 1;
            else if (f3 == 3'd5) begin
                if (f70) ill = 1;
                else code = f75 ? 10 : 8;
            end else code = base[f3];
        end
        e.ctrl = ill ? 5'd0 : 5'(code);
        e.ill  = ill;
        e.mdu  = mdu;
        e.tag  = tag;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                         input logic f70, input logic [3:0] tag);
        in_valid    = 1'b1;
        in_aluop    = op;
        in_funct3   = f3;
        in_funct7_5 = f75;
        in_funct7_0 = f70;
        in_tag      = tag;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; out_ready = 0; mdu_done = 0;
        drive(2'd0, 3'd0, 1'b0, 1'b0, 4'd0);
        in_valid = 1'b0;
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (err_cnt !== '0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        n_checks++; if ({out_ctrl, out_illegal, out_mdu, out_tag} !== '0) begin
            n_fail++; $display("FAIL reset_head: got ctrl=%b ill=%b mdu=%b tag=%0d expected all 0",
                               out_ctrl, out_illegal, out_mdu, out_tag);
        end
        rst = 1'b0;
        exp_err = 0;
        tick();
        $display("reset released");
    endtask

    task automatic test_decode_sra();
        out_ready = 1'b0;
        drive(2'd2, 3'd5, 1'b1, 1'b0, 4'd3);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sra_pre_valid: got %b expected 0", out_valid); end
        tick();
        in_valid = 1'b0;
        $display("push R sra tag=3 -> ctrl=%b ill=%b tag=%0d", out_ctrl, out_illegal, out_tag);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sra_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_ctrl !== 5'b01010) begin n_fail++; $display("FAIL sra_ctrl: got %b expected 01010", out_ctrl); end
        n_checks++; if (out_tag !== 4'd3) begin n_fail++; $display("FAIL sra_tag: got %0d expected 3", out_tag); end
        n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL sra_illegal: got %b expected 0", out_illegal); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sra_popped: got %b expected 0", out_valid); end
    endtask

    task automatic test_illegal();
        int refused;
        int total;
        out_ready = 1'b0;
        drive(2'd2, 3'd2, 1'b1, 1'b0, 4'd4);
        tick();
        in_valid = 1'b0;
        exp_err = 1;
        $display("push R slt f7_5=1 tag=4 -> ctrl=%b ill=%b err_cnt=%0d", out_ctrl, out_illegal, err_cnt);
        n_checks++; if (out_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flag: got %b expected 1", out_illegal); end
        n_checks++; if (out_ctrl !== '0) begin n_fail++; $display("FAIL ill_ctrl: got %b expected 00000", out_ctrl); end
        n_checks++; if (err_cnt !== ERR_CNT_W'(exp_err)) begin n_fail++; $display("FAIL ill_err_cnt: got %0d expected %0d", err_cnt, exp_err); end
        out_ready = 1'b1;
        tick();
        refused = 0;
        total = (1 << ERR_CNT_W) + 3;
        for (int i = 0; i < total; i++) begin
            drive(2'd3, 3'd1, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom));
            if (in_ready !== 1'b1) refused++;
            tick();
            if (exp_err < ERR_MAX) exp_err++;
            if (i == 200) begin
                n_checks++; if (err_cnt !== ERR_CNT_W'(exp_err)) begin n_fail++; $display("FAIL err_cnt_mid: got %0d expected %0d", err_cnt, exp_err); end
            end
        end
        in_valid = 1'b0;
        tick();
        tick();
        $display("sent %0d illegal pushes -> err_cnt=%0d", total, err_cnt);
        n_checks++; if (refused != 0) begin n_fail++; $display("FAIL sat_refused: got %0d refused expected 0", refused); end
        n_checks++; if (err_cnt !== ERR_CNT_W'(ERR_MAX)) begin n_fail++; $display("FAIL err_cnt_sat: got %0d expected %0d", err_cnt, ERR_MAX); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_drained: got %b expected 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            drive(2'd0, 3'($urandom), 1'($urandom), 1'($urandom), 4'(5 + k));
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
        n_checks++; if (out_tag !== 4'd5) begin n_fail++; $display("FAIL full_head: got %0d expected 5", out_tag); end
        drive(2'd1, 3'd0, 1'b0, 1'b0, 4'd7);
        out_ready = 1'b1;
        tick();
        $display("pop tag=5 with refused push tag=7 -> head=%0d in_ready=%b", out_tag, in_ready);
        n_checks++; if (out_tag !== 4'd6 || out_valid !== 1'b1) begin n_fail++; $display("FAIL order_1: got tag=%0d valid=%b expected 6/1", out_tag, out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL order_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        $display("pop tag=6 with push tag=7 -> head=%0d", out_tag);
        n_checks++; if (out_tag !== 4'd7 || out_ctrl !== 5'b00110) begin n_fail++; $display("FAIL order_2: got tag=%0d ctrl=%b expected 7/00110", out_tag, out_ctrl); end
        tick();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL order_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_mdu();
        out_ready = 1'b0;
        drive(2'd2, 3'd0, 1'b0, 1'b1, 4'd1);
        tick();
        $display("push MUL tag=1 -> ctrl=%b ill=%b mdu=%b", out_ctrl, out_illegal, out_mdu);
`ifdef ALUCTRL_RV32M_EN
        n_checks++; if (out_ctrl !== 5'b10000 || out_mdu !== 1'b1) begin n_fail++; $display("FAIL mul_decode: got ctrl=%b mdu=%b expected 10000/1", out_ctrl, out_mdu); end
        drive(2'd0, 3'd3, 1'b1, 1'b0, 4'd2);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mdu_wait_%0d: got busy=%b valid=%b expected 1/0", c, busy, out_valid); end
            tick();
        end
        mdu_done = 1'b1;
        tick();
        mdu_done = 1'b0;
        $display("mdu_done -> busy=%b valid=%b ctrl=%b tag=%0d", busy, out_valid, out_ctrl, out_tag);
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL mdu_resume: got busy=%b valid=%b expected 0/1", busy, out_valid); end
        n_checks++; if (out_ctrl !== 5'b00010 || out_tag !== 4'd2) begin n_fail++; $display("FAIL mdu_next: got ctrl=%b tag=%0d expected 00010/2", out_ctrl, out_tag); end
        tick();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mdu_drained: got %b expected 0", out_valid); end
`else
        in_valid = 1'b0;
        if (exp_err < ERR_MAX) exp_err++;
        n_checks++; if (out_illegal !== 1'b1 || out_mdu !== 1'b0 || out_ctrl !== '0) begin n_fail++; $display("FAIL mul_illegal: got ill=%b mdu=%b ctrl=%b expected 1/0/00000", out_illegal, out_mdu, out_ctrl); end
        n_checks++; if (err_cnt !== ERR_CNT_W'(exp_err)) begin n_fail++; $display("FAIL mul_err_cnt: got %0d expected %0d", err_cnt, exp_err); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_%0d: got %b expected 0", c, busy); end
            tick();
        end
`endif
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(2'd2, 3'd0, 1'b0, 1'b1, 4'd1);
        tick();
        out_ready = 1'b1;
        drive(2'd0, 3'd0, 1'b0, 1'b0, 4'd2);
        tick();
        out_ready = MEN;
        drive(2'd1, 3'd0, 1'b0, 1'b0, 4'd3);
        tick();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0 || busy !== MEN) begin n_fail++; $display("FAIL pre_rst: got in_ready=%b busy=%b expected 0/%b", in_ready, busy, MEN); end
        #2;
        rst = 1'b1;
        #1;
        exp_err = 0;
        $display("async reset mid-cycle -> valid=%b ready=%b busy=%b err=%0d", out_valid, in_ready, busy, err_cnt);
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL arst_flags: got valid=%b ready=%b busy=%b expected 0/1/0", out_valid, in_ready, busy); end
        n_checks++; if (err_cnt !== '0) begin n_fail++; $display("FAIL arst_err_cnt: got %0d expected 0", err_cnt); end
        n_checks++; if ({out_ctrl, out_illegal, out_mdu, out_tag} !== '0) begin n_fail++; $display("FAIL arst_head: got ctrl=%b ill=%b mdu=%b tag=%0d expected 0", out_ctrl, out_illegal, out_mdu, out_tag); end
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        drive(2'd1, 3'd6, 1'b1, 1'b1, 4'd9);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_latency: got %b expected 0", out_valid); end
        tick();
        in_valid = 1'b0;
        $display("first push after reset tag=9 -> valid=%b ctrl=%b", out_valid, out_ctrl);
        n_checks++; if (out_valid !== 1'b1 || out_ctrl !== 5'b00110 || out_tag !== 4'd9) begin n_fail++; $display("FAIL arst_push: got valid=%b ctrl=%b tag=%0d expected 1/00110/9", out_valid, out_ctrl, out_tag); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        ent_t e;
        ent_t h;
        bit   exp_valid;
        bit   acc_push;
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; mdu_done = 1'b0;
        tick();
        rst = 1'b0;
        q.delete();
        m_wait = 0;
        exp_err = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            drive(2'($urandom), 3'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom));
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            mdu_done  = ($urandom_range(0, 3) == 0);
            exp_valid = !m_wait && (q.size() > 0);
            n_checks++; if (out_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b expected %b", cyc, out_valid, exp_valid); end
            n_checks++; if (in_ready !== (q.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, in_ready, q.size() < DEPTH); end
            n_checks++; if (busy !== m_wait) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b expected %b", cyc, busy, m_wait); end
            n_checks++; if (err_cnt !== ERR_CNT_W'(exp_err)) begin n_fail++; $display("FAIL rnd_err@%0d: got %0d expected %0d", cyc, err_cnt, exp_err); end
            if (exp_valid) begin
                h = q[0];
                n_checks++;
                if ({out_ctrl, out_illegal, out_mdu, out_tag} !== {h.ctrl, h.ill, h.mdu, h.tag}) begin
                    n_fail++;
                    $display("FAIL rnd_head@%0d: got ctrl=%b ill=%b mdu=%b tag=%0d expected ctrl=%b ill=%b mdu=%b tag=%0d",
                             cyc, out_ctrl, out_illegal, out_mdu, out_tag, h.ctrl, h.ill, h.mdu, h.tag);
                end
            end
            acc_push = in_valid && (q.size() < DEPTH);
            if (m_wait) begin
                if (mdu_done) m_wait = 0;
            end else if (exp_valid && out_ready) begin
                h = q.pop_front();
                if (h.mdu) m_wait = 1;
                $display("cycle %0d dispatch tag=%0d ctrl=%b ill=%b mdu=%b", cyc, h.tag, h.ctrl, h.ill, h.mdu);
            end
            if (acc_push) begin
                e = ref_decode(in_aluop, in_funct3, in_funct7_5, in_funct7_0, in_tag);
                q.push_back(e);
                if (e.ill && exp_err < ERR_MAX) exp_err++;
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        mdu_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode_sra();
        test_illegal();
        test_back_to_back();
        test_mdu();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_pipe.md
Name: alu_ctrl_pipe

Overview:
- Next-generation ALU control decoder: decodes ALUop/funct3/funct7 into an ALU control code, flags illegal encodings, and buffers results in a small output FIFO with valid/ready handshakes on both sides.
- Sits between the decode stage and the ALU/MDU issue point.
- Stalls dispatch while a multi-cycle multiply/divide operation is outstanding.

Parameters:
- CTRL_W, 5, width of out_ctrl; must be ≥5 when ALUCTRL_RV32M_EN is defined, otherwise ≥4.
- DEPTH, 2, output FIFO entries; power of two, ≥2.
- TAG_W, 4, width of the opaque tag carried alongside each op.
- ERR_CNT_W, 8, width of the saturating illegal-op counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode request valid.
- in_ready  out  1  block can accept a request.
- in_aluop  in  2  00 load/store add, 01 branch sub, 10 R-type, 11 I-type.
- in_funct3  in  3  instruction funct3.
- in_funct7_5  in  1  instruction bit 30.
- in_funct7_0  in  1  instruction bit 25.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  FIFO head available for dispatch.
- out_ready  in  1  consumer takes the head.
- out_ctrl  out  CTRL_W  ALU control code.
- out_illegal  out  1  head entry was an illegal encoding.
- out_mdu  out  1  head entry is an M-extension op.
- out_tag  out  TAG_W  tag of the head entry.
- mdu_done  in  1  one-cycle pulse: outstanding MDU op finished.
- busy  out  1  state is MDU_WAIT.
- err_cnt  out  ERR_CNT_W  count of illegal ops accepted.

Behaviour:
- Codes, zero-extended to CTRL_W:
  - AND=0000, OR=0001, ADD=0010, SLL=0011, SLT=0100, SLTU=0101, SUB=0110, XOR=0111, SRL=1000, SRA=1010.
  - M ops = {2'b10, funct3}: MUL=10000 through REMU=10111.
- Decode:
  - aluop 00 → ADD; aluop 01 → SUB. Funct fields are ignored for both.
  - aluop 10 with funct7_0=1 → M op (with macro only).
  - aluop 10 otherwise: funct7_5=1 is legal only with funct3 000 (SUB) or 101 (SRA). funct3 000 gives ADD/SUB, 101 gives SRL/SRA; the rest map by funct3.
  - aluop 11: funct3 001 requires funct7_5=0 and funct7_0=0 (SLLI). funct3 101 requires funct7_0=0, with funct7_5 selecting SRLI/SRAI. All other funct3 ignore funct7 bits.
- Illegal encoding: ctrl=0, illegal=1, mdu=0. The block never emits X.
- Accept when in_valid && in_ready.
  - The decoded entry is written to the FIFO tail.
  - Visible at the head with out_valid=1 on the next cycle (latency 1).
- in_ready = !full. It does not depend on out_ready or state, so a push is refused when full even if a pop happens in the same cycle.
- Pop when out_valid && out_ready. Simultaneous push and pop when not full: count is unchanged and the pointers advance.
- FIFO pointers wrap modulo DEPTH. Full and empty are tracked with an extra pointer bit.
- FSM states:
  - RUN: out_valid = !empty.
  - RUN → MDU_WAIT on a pop with out_mdu=1.
  - MDU_WAIT: out_valid=0, busy=1. Pushes continue while not full.
  - MDU_WAIT → RUN on mdu_done. out_valid can reassert on the following cycle.
  - mdu_done is ignored in RUN.
- err_cnt increments on each accepted illegal entry and saturates at all-ones.
- Reset, at any time including mid-transaction:
  - FIFO is emptied and state goes to RUN.
  - out_valid=0, in_ready=1, busy=0, err_cnt=0.
  - Head-data outputs (out_ctrl, out_illegal, out_mdu, out_tag) read 0.

Optional Feature:
- Macro: ALUCTRL_RV32M_EN.
- Defined:
  - aluop 10 with funct7_0=1 decodes to M ops with out_mdu=1.
  - The MDU_WAIT state and mdu_done are active.
- Undefined:
  - aluop 10 with funct7_0=1 is illegal.
  - out_mdu and busy are tied to 0; mdu_done is ignored; the FSM reduces to RUN.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - ALU code localparams (ALU_AND … ALU_SRA, ALU_MDU_BASE);
  - ALUOP_MEM/BR/R/I constants;
  - the FSM state enum.
- Natural sub-module: alu_ctrl_fifo, a generic DEPTH×(CTRL_W+2+TAG_W) sync FIFO with full/empty. Decode and FSM stay in the top module.

Test Plan:
- Reset released, then push aluop=10, funct3=101, f7_5=1, tag=3 → next cycle out_valid=1, ctrl=01010, tag=3, illegal=0.
- Push aluop=10, funct3=010, f7_5=1 → ctrl=0, illegal=1, err_cnt=1. Force 2^ERR_CNT_W+3 illegal pushes → err_cnt holds at all-ones.
- out_ready=0 with DEPTH pushes → in_ready=0 after the DEPTH-th accept. Then pop and push in the same cycle → entry order preserved, no loss or duplicate.
- Macro on: push MUL (aluop 10, f7_0=1, funct3=000) then ADD, pop MUL → busy=1 and out_valid=0 for 5 cycles. Pulse mdu_done → ADD (00010) is valid the next cycle.
- Macro off: same MUL push → illegal=1, busy stays 0.
- Assert rst asynchronously mid-MDU_WAIT with a full FIFO → outputs take their reset values immediately; first push after release appears 1 cycle later.
